reg_pair_streamer: RTL and testbench

- Read-side companion to the register file's paired write port. The register file writes register pairs (addr, addr+1); this block reads them back as pairs.
- On a start command it sweeps a run of register pairs through the register file's two combinational read ports.
- Each pair is packed into one 2W-bit word and emitted on a valid/ready stream. Used for register dumps to memory and debug readout.

---
 rtl/reg_pair_streamer.sv | 190 +++++++++++++++++++
 tb/tb_reg_pair_streamer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_pair_streamer.sv
// Register-pair read streamer: sweeps (ptr, ptr+1) pairs through two combinational
// register-file read ports and emits them as packed words on a valid/ready stream.
// Optional running checksum of transferred words: define REG_STREAM_CHECKSUM_EN.
module reg_pair_streamer #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic           CLK,
    input  logic           Reset,
    input  logic           start,
    input  logic [D-1:0]   base_addr,
    input  logic [D-1:0]   pair_count,
    output logic [D-1:0]   raddrA,
    output logic [D-1:0]   raddrB,
    input  logic [W-1:0]   data_outA,
    input  logic [W-1:0]   data_outB,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_data,
    output logic           out_last,
    output logic           busy,
    output logic           done
`ifdef REG_STREAM_CHECKSUM_EN
    ,
    output logic [2*W-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } stateT;

    localparam logic [D-1:0] ZERO_D = {D{1'b0}};
    localparam logic [D-1:0] ONE_D  = {{(D-1){1'b0}}, 1'b1};
    localparam logic [D-1:0] TWO_D  = {{(D-2){1'b0}}, 2'b10};

    stateT          stateR;
    stateT          nextStateS;
    logic [D-1:0]   ptrR;
    logic [D-1:0]   remainingR;

    logic [D-1:0]   ptrS;
    logic [D-1:0]   remainingS;
    logic [2*W-1:0] outDataS;
    logic           outValidS;
    logic           outLastS;
    logic           busyS;
    logic           doneS;

    logic           acceptS;
    logic           transferS;
    logic           captureS;
    logic           lastCaptureS;

    assign acceptS      = (stateR == IDLE) && start;
    assign transferS    = out_valid && out_ready;
    // The output slot is free when empty or when its word leaves on this same edge.
    assign captureS     = (stateR == RUN) && (!out_valid || out_ready);
    assign lastCaptureS = captureS && (remainingR == ONE_D);

    assign raddrA = ptrR;
    assign raddrB = ptrR + ONE_D;

    // State register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stateR <= IDLE;
        end else begin
            stateR <= nextStateS;
        end
    end

    // Next-state logic
    always_comb begin
        nextStateS = stateR;
        case (stateR)
            IDLE: begin
                if (acceptS && (pair_count != ZERO_D)) begin
                    nextStateS = RUN;
                end else begin
                    nextStateS = IDLE;
                end
            end
            RUN: begin
                if (lastCaptureS) begin
                    nextStateS = DRAIN;
                end else begin
                    nextStateS = RUN;
                end
            end
            DRAIN: begin
                if (transferS) begin
                    nextStateS = IDLE;
                end else begin
                    nextStateS = DRAIN;
                end
            end
            default: nextStateS = IDLE;
        endcase
    end

    // Output and datapath next values; everything holds unless the state acts on it
    always_comb begin
        ptrS       = ptrR;
        remainingS = remainingR;
        outDataS   = out_data;
        outValidS  = out_valid;
        outLastS   = out_last;
        busyS      = busy;
        doneS      = 1'b0;
        case (stateR)
            IDLE: begin
                if (acceptS && (pair_count != ZERO_D)) begin
                    ptrS       = base_addr;
                    remainingS = pair_count;
                    busyS      = 1'b1;
                end else if (acceptS) begin
                    doneS = 1'b1;
                end else begin
                    doneS = 1'b0;
                end
            end
            RUN: begin
                if (captureS) begin
                    outDataS   = {data_outA, data_outB};
                    outValidS  = 1'b1;
                    outLastS   = (remainingR == ONE_D);
                    ptrS       = ptrR + TWO_D;
                    remainingS = (remainingR != ZERO_D) ? (remainingR - ONE_D) : ZERO_D;
                end else begin
                    outValidS = out_valid;
                end
            end
            DRAIN: begin
                if (transferS) begin
                    outValidS = 1'b0;
                    outLastS  = 1'b0;
                    busyS     = 1'b0;
                    doneS     = 1'b1;
                end else begin
                    outValidS = out_valid;
                end
            end
            default: begin
                outValidS = 1'b0;
                outLastS  = 1'b0;
                busyS     = 1'b0;
            end
        endcase
    end

    // Datapath and registered stream outputs
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ptrR       <= ZERO_D;
            remainingR <= ZERO_D;
            out_data   <= {(2*W){1'b0}};
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            ptrR       <= ptrS;
            remainingR <= remainingS;
            out_data   <= outDataS;
            out_valid  <= outValidS;
            out_last   <= outLastS;
            busy       <= busyS;
            done       <= doneS;
        end
    end

`ifdef REG_STREAM_CHECKSUM_EN
    // Running sum of transferred words, cleared by any accepted start
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            checksum <= {(2*W){1'b0}};
        end else if (acceptS) begin
            checksum <= {(2*W){1'b0}};
        end else if (transferS) begin
            checksum <= checksum + out_data;
        end else begin
            checksum <= checksum;
        end
    end
`endif

endmodule

// File: tb/tb_reg_pair_streamer.sv
// Directed self-checking bench for reg_pair_streamer (W=8, D=3, registers preloaded 0x10..0x17).
module tb_reg_pair_streamer;

    logic        CLK;
    logic        Reset;
    logic        start;
    logic [2:0]  base_addr;
    logic [2:0]  pair_count;
    logic [2:0]  raddrA;
    logic [2:0]  raddrB;
    logic [7:0]  data_outA;
    logic [7:0]  data_outB;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef REG_STREAM_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    logic [7:0] regFile [0:7];
    int passCount  = 0;
    int checkCount = 0;

    reg_pair_streamer #(.W(8), .D(3)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .start      (start),
        .base_addr  (base_addr),
        .pair_count (pair_count),
        .raddrA     (raddrA),
        .raddrB     (raddrB),
        .data_outA  (data_outA),
        .data_outB  (data_outB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
`ifdef REG_STREAM_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    assign data_outA = regFile[raddrA];
    assign data_outB = regFile[raddrB];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Status vector used below: {out_valid, out_last, busy, done}
    task automatic launch(input logic [2:0] b, input logic [2:0] c);
        start = 1'b1; base_addr = b; pair_count = c;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic step;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset;
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b0000) $display("FAIL reset_status got %b want %b", {out_valid, out_last, busy, done}, 4'b0000); else passCount++;
        checkCount++; if (out_data !== 16'h0000) $display("FAIL reset_data got %h want %h", out_data, 16'h0000); else passCount++;
        checkCount++; if ({raddrA, raddrB} !== {3'd0, 3'd1}) $display("FAIL reset_addr got %h/%h want 0/1", raddrA, raddrB); else passCount++;
    endtask

    task automatic test_basic;
        launch(3'd2, 3'd2);
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b0010) $display("FAIL basic_start got %b want %b", {out_valid, out_last, busy, done}, 4'b0010); else passCount++;
        step();
        checkCount++; if (out_data !== 16'h1213) $display("FAIL basic_w0 got %h want %h", out_data, 16'h1213); else passCount++;
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b1010) $display("FAIL basic_w0_status got %b want %b", {out_valid, out_last, busy, done}, 4'b1010); else passCount++;
        step();
        checkCount++; if (out_data !== 16'h1415) $display("FAIL basic_w1 got %h want %h", out_data, 16'h1415); else passCount++;
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b1110) $display("FAIL basic_w1_status got %b want %b", {out_valid, out_last, busy, done}, 4'b1110); else passCount++;
        step();
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b0001) $display("FAIL basic_done got %b want %b", {out_valid, out_last, busy, done}, 4'b0001); else passCount++;
        step();
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b0000) $display("FAIL basic_idle got %b want %b", {out_valid, out_last, busy, done}, 4'b0000); else passCount++;
    endtask

    task automatic test_wrap;
        launch(3'd6, 3'd2);
        checkCount++; if ({raddrA, raddrB} !== {3'd6, 3'd7}) $display("FAIL wrap_addr0 got %0d/%0d want 6/7", raddrA, raddrB); else passCount++;
        step();
        checkCount++; if (out_data !== 16'h1617) $display("FAIL wrap_w0 got %h want %h", out_data, 16'h1617); else passCount++;
        checkCount++; if ({raddrA, raddrB} !== {3'd0, 3'd1}) $display("FAIL wrap_addr1 got %0d/%0d want 0/1", raddrA, raddrB); else passCount++;
        step();
        checkCount++; if (out_data !== 16'h1011) $display("FAIL wrap_w1 got %h want %h", out_data, 16'h1011); else passCount++;
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b1110) $display("FAIL wrap_w1_status got %b want %b", {out_valid, out_last, busy, done}, 4'b1110); else passCount++;
        step();
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b0001) $display("FAIL wrap_done got %b want %b", {out_valid, out_last, busy, done}, 4'b0001); else passCount++;
        step();
        launch(3'd7, 3'd1);
        checkCount++; if ({raddrA, raddrB} !== {3'd7, 3'd0}) $display("FAIL wrap7_addr got %0d/%0d want 7/0", raddrA, raddrB); else passCount++;
        step();
        checkCount++; if (out_data !== 16'h1710) $display("FAIL wrap7_w0 got %h want %h", out_data, 16'h1710); else passCount++;
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b1110) $display("FAIL wrap7_status got %b want %b", {out_valid, out_last, busy, done}, 4'b1110); else passCount++;
        step();
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b0001) $display("FAIL wrap7_done got %b want %b", {out_valid, out_last, busy, done}, 4'b0001); else passCount++;
        step();
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        launch(3'd0, 3'd3);
        step();
        checkCount++; if (out_data !== 16'h1011) $display("FAIL bp_first got %h want %h", out_data, 16'h1011); else passCount++;
        for (int i = 0; i < 3; i++) begin
            step();
            checkCount++; if (out_data !== 16'h1011) $display("FAIL bp_hold%0d got %h want %h", i, out_data, 16'h1011); else passCount++;
            checkCount++; if ({out_valid, out_last, busy, done} !== 4'b1010) $display("FAIL bp_hold_status%0d got %b want %b", i, {out_valid, out_last, busy, done}, 4'b1010); else passCount++;
            checkCount++; if (raddrA !== 3'd2) $display("FAIL bp_ptr%0d got %0d want %0d", i, raddrA, 3'd2); else passCount++;
        end
        out_ready = 1'b1;
        step();
        checkCount++; if (out_data !== 16'h1213) $display("FAIL bp_w1 got %h want %h", out_data, 16'h1213); else passCount++;
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b1010) $display("FAIL bp_w1_status got %b want %b", {out_valid, out_last, busy, done}, 4'b1010); else passCount++;
        step();
        checkCount++; if (out_data !== 16'h1415) $display("FAIL bp_w2 got %h want %h", out_data, 16'h1415); else passCount++;
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b1110) $display("FAIL bp_w2_status got %b want %b", {out_valid, out_last, busy, done}, 4'b1110); else passCount++;
        step();
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b0001) $display("FAIL bp_done got %b want %b", {out_valid, out_last, busy, done}, 4'b0001); else passCount++;
        step();
    endtask

    task automatic test_zero_count;
        launch(3'd3, 3'd0);
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b0001) $display("FAIL zero_done got %b want %b", {out_valid, out_last, busy, done}, 4'b0001); else passCount++;
        for (int i = 0; i < 2; i++) begin
            step();
            checkCount++; if ({out_valid, out_last, busy, done} !== 4'b0000) $display("FAIL zero_idle%0d got %b want %b", i, {out_valid, out_last, busy, done}, 4'b0000); else passCount++;
        end
    endtask

    task automatic test_restart_ignored;
        launch(3'd2, 3'd2);
        start = 1'b1; base_addr = 3'd5; pair_count = 3'd3;
        step();
        start = 1'b0;
        checkCount++; if (out_data !== 16'h1213) $display("FAIL restart_w0 got %h want %h", out_data, 16'h1213); else passCount++;
        step();
        checkCount++; if (out_data !== 16'h1415) $display("FAIL restart_w1 got %h want %h", out_data, 16'h1415); else passCount++;
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b1110) $display("FAIL restart_w1_status got %b want %b", {out_valid, out_last, busy, done}, 4'b1110); else passCount++;
        step();
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b0001) $display("FAIL restart_done got %b want %b", {out_valid, out_last, busy, done}, 4'b0001); else passCount++;
        step();
        step();
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b0000) $display("FAIL restart_idle got %b want %b", {out_valid, out_last, busy, done}, 4'b0000); else passCount++;
    endtask

    task automatic test_reset_mid;
        launch(3'd0, 3'd3);
        step();
        step();
        checkCount++; if (out_data !== 16'h1213) $display("FAIL rmid_w1 got %h want %h", out_data, 16'h1213); else passCount++;
        Reset = 1'b1;
        #1;
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b0000) $display("FAIL rmid_status got %b want %b", {out_valid, out_last, busy, done}, 4'b0000); else passCount++;
        checkCount++; if (out_data !== 16'h0000) $display("FAIL rmid_data got %h want %h", out_data, 16'h0000); else passCount++;
        checkCount++; if ({raddrA, raddrB} !== {3'd0, 3'd1}) $display("FAIL rmid_addr got %0d/%0d want 0/1", raddrA, raddrB); else passCount++;
        #2;
        Reset = 1'b0;
        step();
        launch(3'd4, 3'd1);
        step();
        checkCount++; if (out_data !== 16'h1415) $display("FAIL rmid_new got %h want %h", out_data, 16'h1415); else passCount++;
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b1110) $display("FAIL rmid_new_status got %b want %b", {out_valid, out_last, busy, done}, 4'b1110); else passCount++;
        step();
        checkCount++; if ({out_valid, out_last, busy, done} !== 4'b0001) $display("FAIL rmid_done got %b want %b", {out_valid, out_last, busy, done}, 4'b0001); else passCount++;
        step();
    endtask

`ifdef REG_STREAM_CHECKSUM_EN
    task automatic test_checksum;
        launch(3'd2, 3'd2);
        step();
        step();
        step();
        checkCount++; if (checksum !== 16'h2628) $display("FAIL csum_done got %h want %h", checksum, 16'h2628); else passCount++;
        step();
        checkCount++; if (checksum !== 16'h2628) $display("FAIL csum_hold got %h want %h", checksum, 16'h2628); else passCount++;
        launch(3'd1, 3'd0);
        checkCount++; if (checksum !== 16'h0000) $display("FAIL csum_clear got %h want %h", checksum, 16'h0000); else passCount++;
        step();
    endtask
`endif

    initial begin
        for (int i = 0; i < 8; i++) regFile[i] = 8'h10 + 8'(i);
        Reset      = 1'b1;
        start      = 1'b0;
        base_addr  = 3'd0;
        pair_count = 3'd0;
        out_ready  = 1'b1;
        #2;
        test_reset();
        #10;
        Reset = 1'b0;
        step();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_count();
        test_restart_ignored();
        test_reset_mid();
`ifdef REG_STREAM_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
